register_bank: RTL and testbench
================================

# register_bank

Parametrised bank of NREG general-purpose registers, each WIDTH bits, sharing one input bus and one function-select code, with a per-register enable mask. It carries forward the established single-cycle functions (inc, dec, load, clear, partial loads, byte-append shift, sign-extend) and adds serial multi-cycle shifts with a Busy/Done handshake, a wrap flag, and two combinational read ports. It sits in the datapath as the general-purpose register file feeding the ALU operand multiplexers.

## Interface
- WIDTH, 32, register width in bits; must be ≥16 and a power of two.
- NREG, 4, number of registers; must be ≥2.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- I  in  WIDTH  data input bus.
- RegSel  in  NREG  enable mask; bit n selects register n.
- FunSel  in  4  function code.
- OutASel, OutBSel  in  $clog2(NREG)  read addresses.
- OutA, OutB  out  WIDTH  combinational read data.
- Busy  out  1  serial shift in progress.
- Done  out  1  one-cycle pulse when a serial shift completes.
- Wrap  out  1  one-cycle pulse when an inc/dec wrapped.

## Operation
- A command is accepted on a rising edge when Busy=0 and RegSel≠0. It applies to every register whose RegSel bit is set. Unselected registers hold their value.
- FunSel codes:
  - 0000: Q−1.
  - 0001: Q+1.
  - 0010: Q←I.
  - 0011: Q←0.
  - 0100: Q←zero-extended I[7:0].
  - 0101: Q←zero-extended I[15:0].
  - 0110: Q←{Q[WIDTH−9:0], I[7:0]}.
  - 0111: Q←sign-extended I[15:0].
  - 1000: serial shift left logical.
  - 1001: serial shift right logical.
  - 1010: serial shift right arithmetic.
  - 1011–1111: reserved; no register or flag change.
- For WIDTH=16, codes 0101 and 0111 both reduce to a plain load.
- Serial shifts:
  - Shift amount k = I[$clog2(WIDTH)−1:0] and RegSel are captured at acceptance. The captured mask is used for the whole operation.
  - Each selected register shifts one bit per cycle for k cycles.
  - k=0: no register change, Busy stays 0, Done pulses the next cycle.
- While Busy=1, all inputs except read addresses are ignored. A command presented during Busy is lost, not queued.
- Wrap is set after an accepted inc/dec in which any selected register went from all-ones to 0 (inc) or from 0 to all-ones (dec).
- OutA/OutB show current register contents, including intermediate shift values.
- Shifter FSM states: IDLE → SHIFT (k>0) → DONE → IDLE. IDLE → DONE when k=0.

## Timing
- Reset values: every register 0, Busy 0, Done 0, Wrap 0, FSM in IDLE.
- Reset asserted mid-shift aborts the operation immediately. Registers clear and no Done pulse is produced.
- Single-cycle ops: register updates on the accepting edge. Wrap is high the cycle after that edge, for exactly one cycle.
- Serial op with k>0:
  - Acceptance at edge 0.
  - Busy is high from edge 0 to edge k, i.e. k cycles.
  - Shifts occur at edges 1…k.
  - Done is high from edge k to edge k+1.
  - The next command can be accepted at edge k+1, which is the cycle Done is high.
- Arithmetic right shift replicates the MSB on every step.
- Inc/dec use modulo 2^WIDTH arithmetic unless saturation is configured.

## Configuration
- REGISTER_BANK_SAT_EN defined: inc saturates at all-ones and dec saturates at 0. Wrap pulses when saturation clamps a result; the register holds its value.
- REGISTER_BANK_SAT_EN undefined: inc/dec wrap modulo 2^WIDTH, as described above.

## Structure
- Shared package register_bank_pkg holds:
  - FunSel code localparams (FS_DEC … FS_SRA).
  - FSM state typedef (IDLE, SHIFT, DONE).
- Sub-module register_bank_shifter contains the FSM, shift counter, captured mask and captured direction. It outputs the per-cycle shift strobe, Busy and Done.
- The top level holds the register array, single-cycle function decode and read multiplexers.

## Test plan
- Reset, then load 32'h0000_00FF into R0 and R2 via RegSel=4'b0101 → R0=R2=0xFF; R1 and R3 stay 0.
- R1=0xFFFF_FFFF, FunSel=0001 → R1=0 and Wrap pulses one cycle. With REGISTER_BANK_SAT_EN, R1 stays 0xFFFF_FFFF and Wrap still pulses.
- I=32'h0000_8001 with codes 0111, 0101 and 0110 (each starting from Q=0x1234_5678) → respectively 0xFFFF_8001, 0x0000_8001, 0x3456_7801.
- R0=0x8000_0000, FunSel=1010, k=4 → Busy high 4 cycles, Done pulses at edge 4, R0=0xF800_0000.
- Present FunSel=0011 during a 3-cycle shift → ignored and shift result intact. Then k=0 shift → Busy stays 0 and Done pulses the next cycle.
- Assert Reset at edge 2 of a k=8 shift → all registers 0, Busy 0, no Done pulse.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared definitions for register_bank: function-select codes, shifter FSM
// states and serial-shift directions.
package register_bank_pkg;

    localparam logic [3:0] FS_DEC     = 4'b0000;
    localparam logic [3:0] FS_INC     = 4'b0001;
    localparam logic [3:0] FS_LOAD    = 4'b0010;
    localparam logic [3:0] FS_CLR     = 4'b0011;
    localparam logic [3:0] FS_LOAD8   = 4'b0100;
    localparam logic [3:0] FS_LOAD16  = 4'b0101;
    localparam logic [3:0] FS_APPEND8 = 4'b0110;
    localparam logic [3:0] FS_SEXT16  = 4'b0111;
    localparam logic [3:0] FS_SLL     = 4'b1000;
    localparam logic [3:0] FS_SRL     = 4'b1001;
    localparam logic [3:0] FS_SRA     = 4'b1010;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;

    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_dir_t;

    function automatic logic is_serial(input logic [3:0] fs);
        return (fs == FS_SLL) || (fs == FS_SRL) || (fs == FS_SRA);
    endfunction

    function automatic shift_dir_t dir_of(input logic [3:0] fs);
        case (fs)
            FS_SRL:  return SH_SRL;
            FS_SRA:  return SH_SRA;
            default: return SH_SLL;
        endcase
    endfunction

endpackage

// File: rtl/register_bank_shifter.sv
// Serial-shift sequencer for register_bank: captures amount, mask and
// direction at acceptance, then strobes one shift per cycle.
module register_bank_shifter
    import register_bank_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREG  = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     start,
    input  logic [$clog2(WIDTH)-1:0] amount,
    input  logic [NREG-1:0]          mask,
    input  logic [3:0]               fun,
    output logic                     shift_en,
    output logic [NREG-1:0]          shift_mask,
    output logic [1:0]               shift_dir,
    output logic                     Busy,
    output logic                     Done
);

    localparam int CW = $clog2(WIDTH);

    shift_state_t    state, state_next;
    logic [CW-1:0]   cnt;
    logic [NREG-1:0] mask_q;
    shift_dir_t      dir_q;

    // NOTE: state elements use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mask_q <= '0;
            dir_q  <= SH_SLL;
        end else begin
            state <= state_next;
            if (start) begin
                cnt    <= amount;
                mask_q <= mask;
                dir_q  <= dir_of(fun);
            end else if (state == SHIFT) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                // DONE behaves like IDLE so a command can be taken on the Done cycle.
                Done = (state == DONE);
                if (start) state_next = (amount == '0) ? DONE : SHIFT;
                else       state_next = IDLE;
            end
            SHIFT: begin
                Busy     = 1'b1;
                shift_en = 1'b1;
                if (cnt == CW'(1)) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign shift_mask = mask_q;
    assign shift_dir  = dir_q;

endmodule

// File: rtl/register_bank.sv
// General-purpose register file with single-cycle functions, serial shifts and
// two read ports. Define REGISTER_BANK_SAT_EN for saturating inc/dec.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREG  = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [WIDTH-1:0]        I,
    input  logic [NREG-1:0]         RegSel,
    input  logic [3:0]              FunSel,
    input  logic [$clog2(NREG)-1:0] OutASel,
    input  logic [$clog2(NREG)-1:0] OutBSel,
    output logic [WIDTH-1:0]        OutA,
    output logic [WIDTH-1:0]        OutB,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Wrap
);

    localparam int CW = $clog2(WIDTH);
    localparam int SW = $clog2(NREG);
`ifdef REGISTER_BANK_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [WIDTH-1:0] regs   [NREG];
    logic [WIDTH-1:0] next_q [NREG];
    logic             busy, accept, start, shift_en, wrap_hit, wrap_q;
    logic [NREG-1:0]  shift_mask;
    logic [1:0]       shift_dir;

    assign accept = !busy && (RegSel != '0);
    assign start  = accept && is_serial(FunSel);

    register_bank_shifter #(.WIDTH(WIDTH), .NREG(NREG)) u_shifter (
        .Clock      (Clock),
        .Reset      (Reset),
        .start      (start),
        .amount     (I[CW-1:0]),
        .mask       (RegSel),
        .fun        (FunSel),
        .shift_en   (shift_en),
        .shift_mask (shift_mask),
        .shift_dir  (shift_dir),
        .Busy       (busy),
        .Done       (Done)
    );

    function automatic logic [WIDTH-1:0] apply_fun(input logic [3:0]       fs,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] din);
        logic [WIDTH-1:0] r;
        r = q;
        case (fs)
            FS_DEC:     r = (SAT_EN && q == '0) ? q : q - WIDTH'(1);
            FS_INC:     r = (SAT_EN && q == '1) ? q : q + WIDTH'(1);
            FS_LOAD:    r = din;
            FS_CLR:     r = '0;
            FS_LOAD8:   begin r = '0; r[7:0] = din[7:0]; end
            FS_LOAD16:  begin r = '0; r[15:0] = din[15:0]; end
            FS_APPEND8: r = {q[WIDTH-9:0], din[7:0]};
            FS_SEXT16:  begin r = {WIDTH{din[15]}}; r[15:0] = din[15:0]; end
            default:    r = q;
        endcase
        return r;
    endfunction

    // Shift strobes only occur while busy and commands only while idle, so the
    // two branches below never compete for a register.
    always_comb begin
        wrap_hit = 1'b0;
        for (int n = 0; n < NREG; n++) begin
            next_q[n] = regs[n];
            if (shift_en && shift_mask[n]) begin
                case (shift_dir)
                    SH_SRL:  next_q[n] = {1'b0, regs[n][WIDTH-1:1]};
                    SH_SRA:  next_q[n] = {regs[n][WIDTH-1], regs[n][WIDTH-1:1]};
                    default: next_q[n] = {regs[n][WIDTH-2:0], 1'b0};
                endcase
            end else if (accept && RegSel[n] && !is_serial(FunSel)) begin
                next_q[n] = apply_fun(FunSel, regs[n], I);
                if ((FunSel == FS_INC && regs[n] == '1) ||
                    (FunSel == FS_DEC && regs[n] == '0))
                    wrap_hit = 1'b1;
            end
        end
    end

    // NOTE: the register array is a bank of flops, not a RAM macro, so it is
    // cleared by the asynchronous reset like any other state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int n = 0; n < NREG; n++) regs[n] <= '0;
            wrap_q <= 1'b0;
        end else begin
            for (int n = 0; n < NREG; n++) regs[n] <= next_q[n];
            wrap_q <= wrap_hit;
        end
    end

    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int n = 0; n < NREG; n++) begin
            if (OutASel == SW'(n)) OutA = regs[n];
            if (OutBSel == SW'(n)) OutB = regs[n];
        end
    end

    assign Busy = busy;
    assign Wrap = wrap_q;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank (WIDTH=32, NREG=4); register
// expectations go through a scoreboard queue, flags are checked inline.
module tb_register_bank;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] I = '0;
    logic [3:0]  RegSel = '0;
    logic [3:0]  FunSel = 4'hF;
    logic [1:0]  OutASel = '0;
    logic [1:0]  OutBSel = '0;
    logic [31:0] OutA, OutB;
    logic        Busy, Done, Wrap;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb [$];

`ifdef REGISTER_BANK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [31:0] R1_AFTER_INC = SAT ? 32'hFFFF_FFFF : 32'h0;
    localparam logic [31:0] R3_AFTER_DEC = SAT ? 32'h0 : 32'hFFFF_FFFF;

    register_bank #(.WIDTH(32), .NREG(4)) dut (
        .Clock(Clock), .Reset(Reset), .I(I), .RegSel(RegSel), .FunSel(FunSel),
        .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB),
        .Busy(Busy), .Done(Done), .Wrap(Wrap)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    // Drives one command for a single rising edge; returns at the following negedge.
    task automatic issue(input logic [3:0] fs, input logic [3:0] sel, input logic [31:0] din);
        @(negedge Clock);
        FunSel = fs; RegSel = sel; I = din;
        @(negedge Clock);
        FunSel = 4'hF; RegSel = '0; I = '0;
    endtask

    // Even registers are read through port A, odd ones through port B.
    task automatic read_reg(input int r, output logic [31:0] v);
        if (r % 2 == 1) begin OutBSel = 2'(r); #1; v = OutB; end
        else            begin OutASel = 2'(r); #1; v = OutA; end
    endtask

    task automatic push4(input logic [31:0] a, b, c, d);
        sb.push_back(a); sb.push_back(b); sb.push_back(c); sb.push_back(d);
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] obs, exp_v;
        for (int r = 0; r < 4; r++) begin
            read_reg(r, obs);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL %s R%0d: got %h want %h", tag, r, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        push4(32'h0, 32'h0, 32'h0, 32'h0);
        compare_all("reset");
        vectors++;
        if ({Busy, Done, Wrap} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000", {Busy, Done, Wrap});
        end
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_load_mask;
        issue(4'b0010, 4'b0101, 32'h0000_00FF);
        push4(32'hFF, 32'h0, 32'hFF, 32'h0);
        compare_all("load_mask");
        vectors++;
        if (Wrap !== 1'b0) begin miscompares++; $display("FAIL load_wrap: got %b want 0", Wrap); end
    endtask

    task automatic test_wrap;
        issue(4'b0010, 4'b0010, 32'hFFFF_FFFF);
        issue(4'b0001, 4'b0010, 32'h0);
        vectors++;
        if (Wrap !== 1'b1) begin miscompares++; $display("FAIL inc_wrap: got %b want 1", Wrap); end
        @(negedge Clock);
        vectors++;
        if (Wrap !== 1'b0) begin miscompares++; $display("FAIL inc_wrap_len: got %b want 0", Wrap); end
        issue(4'b0000, 4'b1000, 32'h0);
        vectors++;
        if (Wrap !== 1'b1) begin miscompares++; $display("FAIL dec_wrap: got %b want 1", Wrap); end
        issue(4'b0001, 4'b0001, 32'h0);
        vectors++;
        if (Wrap !== 1'b0) begin miscompares++; $display("FAIL inc_nowrap: got %b want 0", Wrap); end
        push4(32'h100, R1_AFTER_INC, 32'hFF, R3_AFTER_DEC);
        compare_all("wrap");
    endtask

    task automatic test_partial;
        logic [3:0]  codes [4];
        logic [31:0] exps  [4];
        logic [31:0] obs, exp_v;
        codes = '{4'b0111, 4'b0101, 4'b0110, 4'b0100};
        exps  = '{32'hFFFF_8001, 32'h0000_8001, 32'h3456_7801, 32'h0000_0001};
        for (int t = 0; t < 4; t++) begin
            issue(4'b0010, 4'b0100, 32'h1234_5678);
            issue(codes[t], 4'b0100, 32'h0000_8001);
            sb.push_back(exps[t]);
            read_reg(2, obs);
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL partial code %b: got %h want %h", codes[t], obs, exp_v);
            end
        end
        issue(4'b1011, 4'b1111, 32'hDEAD_BEEF);
        vectors++;
        if ({Busy, Done, Wrap} !== 3'b000) begin
            miscompares++;
            $display("FAIL reserved_flags: got %b want 000", {Busy, Done, Wrap});
        end
        push4(32'h100, R1_AFTER_INC, 32'h1, R3_AFTER_DEC);
        compare_all("reserved");
    endtask

    task automatic test_sra;
        int busy_cycles = 0;
        issue(4'b0010, 4'b0001, 32'h8000_0000);
        issue(4'b1010, 4'b0001, 32'h0000_0004);
        sb.push_back(32'hC000_0000);
        for (int c = 0; c < 40 && Busy === 1'b1; c++) begin
            busy_cycles++;
            if (c == 1) begin
                OutASel = 2'd0; #1;
                vectors++;
                if (OutA !== sb[0]) begin
                    miscompares++;
                    $display("FAIL sra_step1: got %h want %h", OutA, sb[0]);
                end
                void'(sb.pop_front());
            end
            @(negedge Clock);
        end
        vectors++;
        if (busy_cycles != 4) begin miscompares++; $display("FAIL sra_busy_cycles: got %0d want 4", busy_cycles); end
        vectors++;
        if (Done !== 1'b1) begin miscompares++; $display("FAIL sra_done: got %b want 1", Done); end
        push4(32'hF800_0000, R1_AFTER_INC, 32'h1, R3_AFTER_DEC);
        compare_all("sra");
        @(negedge Clock);
        vectors++;
        if (Done !== 1'b0) begin miscompares++; $display("FAIL sra_done_len: got %b want 0", Done); end
    endtask

    task automatic test_back_to_back;
        issue(4'b0010, 4'b0010, 32'h0000_00F0);
        issue(4'b1000, 4'b0010, 32'h0000_0003);
        vectors++;
        if (Busy !== 1'b1) begin miscompares++; $display("FAIL sll_busy: got %b want 1", Busy); end
        FunSel = 4'b0011; RegSel = 4'b1111;
        @(negedge Clock);
        FunSel = 4'hF; RegSel = '0;
        for (int c = 0; c < 20 && Done !== 1'b1; c++) @(negedge Clock);
        vectors++;
        if (Done !== 1'b1) begin miscompares++; $display("FAIL sll_done_timeout: got %b want 1", Done); end
        push4(32'hF800_0000, 32'h0000_0780, 32'h1, R3_AFTER_DEC);
        compare_all("busy_ignore");
        FunSel = 4'b0001; RegSel = 4'b0010;
        @(negedge Clock);
        FunSel = 4'hF; RegSel = '0;
        push4(32'hF800_0000, 32'h0000_0781, 32'h1, R3_AFTER_DEC);
        compare_all("accept_on_done");
        issue(4'b1001, 4'b0010, 32'h0);
        vectors++;
        if ({Busy, Done} !== 2'b01) begin miscompares++; $display("FAIL k0_flags: got %b want 01", {Busy, Done}); end
        push4(32'hF800_0000, 32'h0000_0781, 32'h1, R3_AFTER_DEC);
        compare_all("k0");
        @(negedge Clock);
        vectors++;
        if (Done !== 1'b0) begin miscompares++; $display("FAIL k0_done_len: got %b want 0", Done); end
    endtask

    task automatic test_srl;
        int busy_cycles = 0;
        issue(4'b0010, 4'b1111, 32'hF0F0_0001);
        issue(4'b1001, 4'b0011, 32'h0000_0008);
        for (int c = 0; c < 40 && Busy === 1'b1; c++) begin
            busy_cycles++;
            @(negedge Clock);
        end
        vectors++;
        if (busy_cycles != 8) begin miscompares++; $display("FAIL srl_busy_cycles: got %0d want 8", busy_cycles); end
        push4(32'h00F0_F000, 32'h00F0_F000, 32'hF0F0_0001, 32'hF0F0_0001);
        compare_all("srl");
    endtask

    task automatic test_reset_abort;
        int done_seen = 0;
        issue(4'b0010, 4'b1111, 32'hA5A5_A5A5);
        issue(4'b1000, 4'b1111, 32'h0000_0008);
        @(negedge Clock);
        #3;
        Reset = 1'b1;
        #1;
        vectors++;
        if ({Busy, Done} !== 2'b00) begin miscompares++; $display("FAIL abort_flags: got %b want 00", {Busy, Done}); end
        push4(32'h0, 32'h0, 32'h0, 32'h0);
        compare_all("abort");
        @(negedge Clock);
        Reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clock);
            if (Done === 1'b1) done_seen++;
        end
        vectors++;
        if (done_seen != 0) begin miscompares++; $display("FAIL abort_done: got %0d pulses want 0", done_seen); end
        push4(32'h0, 32'h0, 32'h0, 32'h0);
        compare_all("abort_hold");
    endtask

    initial begin
        test_reset;
        test_load_mask;
        test_wrap;
        test_partial;
        test_sra;
        test_back_to_back;
        test_srl;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
